// File: rtl/fpu_vector_engine.sv
// rtl/fpu_vector_engine.sv - on-chip self-check sequencer for the FP add/sub unit
module fpu_vector_engine #(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 4,
    parameter int          NUM_VEC    = 16,
    parameter int          DUT_LAT    = 0,
    parameter logic [3:0]  COMBO_MASK = 4'hF,
    parameter bit          NAN_EQUAL  = 1'b1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic                    i_abort,
    output logic [ADDR_WIDTH-1:0]   o_rom_addr,
    input  logic [DATA_WIDTH-1:0]   i_rom_a,
    input  logic [DATA_WIDTH-1:0]   i_rom_b,
    output logic [ADDR_WIDTH+1:0]   o_exp_addr,
    input  logic [DATA_WIDTH+1:0]   i_exp,
    output logic                    o_add_sub,
    output logic [DATA_WIDTH-1:0]   o_32_a,
    output logic [DATA_WIDTH-1:0]   o_32_b,
    input  logic [DATA_WIDTH-1:0]   i_32_s,
    input  logic                    i_ov_flag,
    input  logic                    i_un_flag,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [ADDR_WIDTH+2:0]   o_pass_cnt,
    output logic [ADDR_WIDTH+2:0]   o_fail_cnt,
    output logic                    o_ff_valid,
    output logic [ADDR_WIDTH+1:0]   o_ff_addr
);

    localparam int CW     = ADDR_WIDTH + 3;
    localparam int LW     = (DUT_LAT > 0) ? $clog2(DUT_LAT + 1) : 1;
    localparam int EXP_W  = (DATA_WIDTH == 64) ? 11 : (DATA_WIDTH == 16) ? 5 : 8;
    localparam int FRAC_W = DATA_WIDTH - 1 - EXP_W;
    localparam logic [ADDR_WIDTH-1:0] LAST_VEC = ADDR_WIDTH'(NUM_VEC - 1);
    localparam logic [LW-1:0]         LAT_LAST = LW'(DUT_LAT);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_DRIVE, S_CHECK, S_DONE
    } state_t;

    // Returns {found, combo}: lowest enabled combo, either from 0 or strictly above cur.
    function automatic logic [2:0] next_combo(input logic [1:0] cur, input logic from_zero);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (COMBO_MASK[i] && (from_zero || (i > int'(cur)))) begin
                r = {1'b1, 2'(i)};
            end
        end
        return r;
    endfunction

    function automatic logic is_nan(input logic [DATA_WIDTH-1:0] w);
        return (&w[DATA_WIDTH-2 -: EXP_W]) && (|w[FRAC_W-1:0]);
    endfunction

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   vector_q, vector_d;
    logic [1:0]              combo_q, combo_d;
    logic [DATA_WIDTH-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
    logic [LW-1:0]           lat_q, lat_d;
    logic [CW-1:0]           pass_q, pass_d, fail_q, fail_d;
    logic                    ff_valid_q, ff_valid_d;
    logic [ADDR_WIDTH+1:0]   ff_addr_q, ff_addr_d;
    logic [ADDR_WIDTH-1:0]   rom_addr_q, rom_addr_d;
    logic [ADDR_WIDTH+1:0]   exp_addr_q, exp_addr_d;
    logic                    add_sub_q, add_sub_d;
    logic [DATA_WIDTH-1:0]   out_a_q, out_a_d, out_b_q, out_b_d;

    logic                    busy;
    logic                    load_drive;
    logic                    match;
    logic [2:0]              first_c, nxt_c;
    logic [DATA_WIDTH-1:0]   src_a, src_b;
    logic [DATA_WIDTH+1:0]   got;

    assign busy    = (state_q != S_IDLE) && (state_q != S_DONE);
    assign first_c = next_combo(2'd0, 1'b1);
    assign nxt_c   = next_combo(combo_q, 1'b0);
    // Operand registers are written at the end of LOAD, so the first DRIVE takes ROM data directly.
    assign src_a   = (state_q == S_LOAD) ? i_rom_a : op_a_q;
    assign src_b   = (state_q == S_LOAD) ? i_rom_b : op_b_q;
    assign got     = {i_ov_flag, i_un_flag, i_32_s};
    assign match   = (got == i_exp) ||
                     (NAN_EQUAL && (got[DATA_WIDTH+1:DATA_WIDTH] == i_exp[DATA_WIDTH+1:DATA_WIDTH]) &&
                      is_nan(i_32_s) && is_nan(i_exp[DATA_WIDTH-1:0]));

    always_comb begin
        state_d    = state_q;
        vector_d   = vector_q;
        combo_d    = combo_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        lat_d      = lat_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        ff_valid_d = ff_valid_q;
        ff_addr_d  = ff_addr_q;
        rom_addr_d = rom_addr_q;
        exp_addr_d = exp_addr_q;
        add_sub_d  = add_sub_q;
        out_a_d    = out_a_q;
        out_b_d    = out_b_q;
        load_drive = 1'b0;

        if (busy && i_abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        pass_d     = '0;
                        fail_d     = '0;
                        ff_valid_d = 1'b0;
                        ff_addr_d  = '0;
                        vector_d   = '0;
                        combo_d    = '0;
                        rom_addr_d = '0;
                        state_d    = first_c[2] ? S_FETCH : S_DONE;
                    end
                end
                S_FETCH: begin
                    state_d = S_LOAD;
                end
                S_LOAD: begin
                    op_a_d     = i_rom_a;
                    op_b_d     = i_rom_b;
                    combo_d    = first_c[1:0];
                    state_d    = S_DRIVE;
                    load_drive = 1'b1;
                end
                S_DRIVE: begin
                    if (lat_q == LAT_LAST) begin
                        lat_d   = '0;
                        state_d = S_CHECK;
                    end else begin
                        lat_d = lat_q + 1'b1;
                    end
                end
                S_CHECK: begin
                    if (match) begin
                        if (pass_q != {CW{1'b1}}) pass_d = pass_q + 1'b1;
                    end else begin
                        if (fail_q != {CW{1'b1}}) fail_d = fail_q + 1'b1;
                        if (!ff_valid_q) begin
                            ff_valid_d = 1'b1;
                            ff_addr_d  = {vector_q, combo_q};
                        end
                    end
                    if (nxt_c[2]) begin
                        combo_d    = nxt_c[1:0];
                        state_d    = S_DRIVE;
                        load_drive = 1'b1;
                    end else if (vector_q == LAST_VEC) begin
                        state_d = S_DONE;
                    end else begin
                        vector_d   = vector_q + 1'b1;
                        rom_addr_d = vector_q + 1'b1;
                        state_d    = S_FETCH;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // FPU-facing outputs change only on DRIVE entry and then hold through CHECK.
        if (load_drive) begin
            add_sub_d  = combo_d[1];
            out_a_d    = combo_d[0] ? src_b : src_a;
            out_b_d    = combo_d[0] ? src_a : src_b;
            exp_addr_d = {vector_q, combo_d};
            lat_d      = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            vector_q   <= '0;
            combo_q    <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            lat_q      <= '0;
            pass_q     <= '0;
            fail_q     <= '0;
            ff_valid_q <= 1'b0;
            ff_addr_q  <= '0;
            rom_addr_q <= '0;
            exp_addr_q <= '0;
            add_sub_q  <= 1'b0;
            out_a_q    <= '0;
            out_b_q    <= '0;
        end else begin
            state_q    <= state_d;
            vector_q   <= vector_d;
            combo_q    <= combo_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            lat_q      <= lat_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            ff_valid_q <= ff_valid_d;
            ff_addr_q  <= ff_addr_d;
            rom_addr_q <= rom_addr_d;
            exp_addr_q <= exp_addr_d;
            add_sub_q  <= add_sub_d;
            out_a_q    <= out_a_d;
            out_b_q    <= out_b_d;
        end
    end

    assign o_rom_addr = rom_addr_q;
    assign o_exp_addr = exp_addr_q;
    assign o_add_sub  = add_sub_q;
    assign o_32_a     = out_a_q;
    assign o_32_b     = out_b_q;
    assign o_busy     = busy;
    assign o_done     = (state_q == S_DONE);
    assign o_pass_cnt = pass_q;
    assign o_fail_cnt = fail_q;
    assign o_ff_valid = ff_valid_q;
    assign o_ff_addr  = ff_addr_q;

endmodule

// File: tb/tb_fpu_vector_engine.sv
// tb/tb_fpu_vector_engine.sv - self-checking bench for fpu_vector_engine
module tb_fpu_vector_engine;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [2:0]      start_r = '0;
    logic [2:0]      abort_r = '0;
    logic [2:0]      done_w, busy_w, ffv_w;
    logic [2:0][6:0] pass_w, fail_w;
    logic [2:0][5:0] ffa_w;

    // Stand-in FPU: exact for the small operands used in directed tests, a fixed hash otherwise.
    function automatic logic [33:0] fpu_fn(input logic sub, input logic [31:0] x, input logic [31:0] y);
        int vx, vy, r;
        logic [31:0] s;
        if ((x == 32'h3F800000 || x == 32'h40000000) && (y == 32'h3F800000 || y == 32'h40000000)) begin
            vx = (x == 32'h3F800000) ? 1 : 2;
            vy = (y == 32'h3F800000) ? 1 : 2;
            r  = sub ? vx - vy : vx + vy;
            case (r)
                -1:      s = 32'hBF800000;
                0:       s = 32'h00000000;
                1:       s = 32'h3F800000;
                2:       s = 32'h40000000;
                3:       s = 32'h40400000;
                default: s = 32'h40800000;
            endcase
            return {2'b00, s};
        end
        if (x == 32'h7F800000 && y == 32'h7F800000)
            return {2'b00, sub ? 32'h7FC00000 : 32'h7F800000};
        s = x ^ {y[15:0], y[31:16]} ^ (sub ? 32'hA5A50F0F : 32'h12345678);
        return {s[3] ^ x[0], s[7] & y[1], s};
    endfunction

    function automatic bit fp_match(input logic [33:0] g, input logic [33:0] e, input bit nan_eq);
        bit gn, en;
        gn = (g[30:23] == 8'hFF) && (g[22:0] != 0);
        en = (e[30:23] == 8'hFF) && (e[22:0] != 0);
        return (g == e) || (nan_eq && g[33:32] == e[33:32] && gn && en);
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Instance A: 1 vector, all combos, combinational FPU, NaN-equal
    logic [31:0] ra_a [16];
    logic [31:0] ra_b [16];
    logic [33:0] exp_a [64];
    logic [3:0]  a_rom_addr;
    logic [5:0]  a_exp_addr;
    logic [31:0] a_rom_a, a_rom_b, a_32a, a_32b, a_s;
    logic [33:0] a_exp;
    logic        a_add_sub, a_ov, a_un;

    always @(posedge clk) begin
        a_rom_a <= ra_a[a_rom_addr];
        a_rom_b <= ra_b[a_rom_addr];
        a_exp   <= exp_a[a_exp_addr];
    end
    assign {a_ov, a_un, a_s} = fpu_fn(a_add_sub, a_32a, a_32b);

    fpu_vector_engine #(.NUM_VEC(1), .DUT_LAT(0), .COMBO_MASK(4'hF), .NAN_EQUAL(1'b1)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_r[0]), .i_abort(abort_r[0]),
        .o_rom_addr(a_rom_addr), .i_rom_a(a_rom_a), .i_rom_b(a_rom_b),
        .o_exp_addr(a_exp_addr), .i_exp(a_exp),
        .o_add_sub(a_add_sub), .o_32_a(a_32a), .o_32_b(a_32b),
        .i_32_s(a_s), .i_ov_flag(a_ov), .i_un_flag(a_un),
        .o_busy(busy_w[0]), .o_done(done_w[0]), .o_pass_cnt(pass_w[0]), .o_fail_cnt(fail_w[0]),
        .o_ff_valid(ffv_w[0]), .o_ff_addr(ffa_w[0]));

    // Instance B: 16 vectors, a+b and a-b, 3-stage pipelined FPU, exact NaN compare
    logic [31:0] rb_a [16];
    logic [31:0] rb_b [16];
    logic [33:0] exp_b [64];
    logic [3:0]  b_rom_addr;
    logic [5:0]  b_exp_addr;
    logic [31:0] b_rom_a, b_rom_b, b_32a, b_32b, b_s;
    logic [33:0] b_exp;
    logic [33:0] bp [3];
    logic        b_add_sub, b_ov, b_un;

    always @(posedge clk) begin
        b_rom_a <= rb_a[b_rom_addr];
        b_rom_b <= rb_b[b_rom_addr];
        b_exp   <= exp_b[b_exp_addr];
        bp[0]   <= fpu_fn(b_add_sub, b_32a, b_32b);
        bp[1]   <= bp[0];
        bp[2]   <= bp[1];
    end
    assign {b_ov, b_un, b_s} = bp[2];

    fpu_vector_engine #(.NUM_VEC(16), .DUT_LAT(3), .COMBO_MASK(4'b0101), .NAN_EQUAL(1'b0)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_r[1]), .i_abort(abort_r[1]),
        .o_rom_addr(b_rom_addr), .i_rom_a(b_rom_a), .i_rom_b(b_rom_b),
        .o_exp_addr(b_exp_addr), .i_exp(b_exp),
        .o_add_sub(b_add_sub), .o_32_a(b_32a), .o_32_b(b_32b),
        .i_32_s(b_s), .i_ov_flag(b_ov), .i_un_flag(b_un),
        .o_busy(busy_w[1]), .o_done(done_w[1]), .o_pass_cnt(pass_w[1]), .o_fail_cnt(fail_w[1]),
        .o_ff_valid(ffv_w[1]), .o_ff_addr(ffa_w[1]));

    // Instance C: no combos enabled
    logic [3:0]  c_rom_addr;
    logic [5:0]  c_exp_addr;
    logic [31:0] c_32a, c_32b;
    logic        c_add_sub;

    fpu_vector_engine #(.NUM_VEC(1), .COMBO_MASK(4'h0)) u_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_r[2]), .i_abort(abort_r[2]),
        .o_rom_addr(c_rom_addr), .i_rom_a(32'h0), .i_rom_b(32'h0),
        .o_exp_addr(c_exp_addr), .i_exp(34'h0),
        .o_add_sub(c_add_sub), .o_32_a(c_32a), .o_32_b(c_32b),
        .i_32_s(32'h0), .i_ov_flag(1'b0), .i_un_flag(1'b0),
        .o_busy(busy_w[2]), .o_done(done_w[2]), .o_pass_cnt(pass_w[2]), .o_fail_cnt(fail_w[2]),
        .o_ff_valid(ffv_w[2]), .o_ff_addr(ffa_w[2]));

    logic [70:0] drv [4];

    // Start instance w, optionally re-pulse start at cycle 'poke' while busy, wait for o_done.
    task automatic run(input int w, input int poke, output int cyc);
        @(negedge clk);
        start_r[w] = 1'b1;
        @(posedge clk); #1;
        start_r[w] = 1'b0;
        cyc = 0;
        chk("start_clears_pass", 64'(pass_w[w]), 0);
        chk("start_clears_fail", 64'(fail_w[w]), 0);
        chk("start_clears_ffv", 64'(ffv_w[w]), 0);
        chk("start_busy", 64'(busy_w[w]), (w != 2) ? 1 : 0);
        while (!done_w[w] && cyc < 1000) begin
            start_r[w] = (cyc == poke);
            @(posedge clk); #1;
            cyc++;
            if (w == 0 && cyc >= 2 && cyc <= 8 && (cyc % 2) == 0)
                drv[cyc/2-1] = {a_add_sub, a_32a, a_32b, a_exp_addr};
        end
        start_r[w] = 1'b0;
        chk("done_seen_busy_low", 64'(busy_w[w]), 0);
        @(posedge clk); #1;
        chk("done_one_cycle", 64'(done_w[w]), 0);
    endtask

    task automatic model_b(input int nvec, output int p, output int f,
                           output logic ffv, output logic [5:0] ffa);
        logic [3:0]  mb;
        logic [31:0] x, y;
        logic [33:0] g;
        mb = 4'b0101;
        p = 0; f = 0; ffv = 1'b0; ffa = '0;
        for (int v = 0; v < nvec; v++) begin
            for (int c = 0; c < 4; c++) begin
                if (mb[c]) begin
                    x = c[0] ? rb_b[v] : rb_a[v];
                    y = c[0] ? rb_a[v] : rb_b[v];
                    g = fpu_fn(c[1], x, y);
                    if (fp_match(g, exp_b[v*4+c], 1'b0)) p++;
                    else begin
                        f++;
                        if (!ffv) begin ffv = 1'b1; ffa = 6'(v*4 + c); end
                    end
                end
            end
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          cc;
        logic [33:0] cv;
        bit          nan_exp;
        int          p;
        int          f;
        logic        ffv;
        logic [5:0]  ffa;
    } rec_t;

    rec_t tbl [4];

    initial begin
        int cyc, n, mp, mf;
        logic mffv, seen;
        logic [5:0] mffa;
        logic [31:0] x, y;

        tbl[0] = '{32'h3F800000, 32'h40000000, -1, 34'h0, 1'b0, 4, 0, 1'b0, 6'd0};
        tbl[1] = '{32'h3F800000, 32'h40000000,  2, {2'b00, 32'hBF800001}, 1'b0, 3, 1, 1'b1, 6'd2};
        tbl[2] = '{32'h7F800000, 32'h7F800000, -1, 34'h0, 1'b1, 4, 0, 1'b0, 6'd0};
        tbl[3] = '{32'h40000000, 32'h3F800000,  0, {2'b10, 32'h40400000}, 1'b0, 3, 1, 1'b1, 6'd0};

        for (int i = 0; i < 16; i++) begin
            ra_a[i] = '0; ra_b[i] = '0;
            rb_a[i] = $urandom;
            rb_b[i] = $urandom;
            if (i % 5 == 3) begin rb_a[i] = 32'h7F800000; rb_b[i] = 32'h7F800000; end
        end
        for (int i = 0; i < 64; i++) begin
            exp_a[i] = '0;
            x = i[0] ? rb_b[i/4] : rb_a[i/4];
            y = i[0] ? rb_a[i/4] : rb_b[i/4];
            exp_b[i] = fpu_fn(i[1], x, y);
            if ($urandom_range(3) == 0) exp_b[i] = exp_b[i] ^ (34'd1 << $urandom_range(33));
            if ((i/4) % 5 == 3 && i[1]) exp_b[i] = {2'b00, 32'hFFC00001};
        end

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy_a", 64'(busy_w[0]), 0);
        chk("rst_done_b", 64'(done_w[1]), 0);
        chk("rst_pass_b", 64'(pass_w[1]), 0);
        chk("rst_out_a", 64'(a_32a), 0);
        chk("rst_exp_addr_b", 64'(b_exp_addr), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            ra_a[0] = tbl[t].a;
            ra_b[0] = tbl[t].b;
            for (int c = 0; c < 4; c++) begin
                x = c[0] ? tbl[t].b : tbl[t].a;
                y = c[0] ? tbl[t].a : tbl[t].b;
                exp_a[c] = fpu_fn(c[1], x, y);
                if (tbl[t].nan_exp && c[1]) exp_a[c] = {2'b00, 32'hFFC00001};
                if (c == tbl[t].cc) exp_a[c] = tbl[t].cv;
            end
            run(0, -1, cyc);
            chk($sformatf("a%0d_cycles", t), 64'(cyc), 10);
            chk($sformatf("a%0d_pass", t), 64'(pass_w[0]), 64'(tbl[t].p));
            chk($sformatf("a%0d_fail", t), 64'(fail_w[0]), 64'(tbl[t].f));
            chk($sformatf("a%0d_ffv", t), 64'(ffv_w[0]), 64'(tbl[t].ffv));
            if (tbl[t].ffv) chk($sformatf("a%0d_ffa", t), 64'(ffa_w[0]), 64'(tbl[t].ffa));
            if (t == 0) begin
                for (int k = 0; k < 4; k++) begin
                    x = k[0] ? tbl[0].b : tbl[0].a;
                    y = k[0] ? tbl[0].a : tbl[0].b;
                    chk($sformatf("a_drive_combo%0d", k), 64'(drv[k]), 64'({k[1], x, y, 6'(k)}));
                end
            end
        end

        run(2, -1, cyc);
        chk("mask0_cycles", 64'(cyc), 0);
        chk("mask0_pass", 64'(pass_w[2]), 0);
        chk("mask0_fail", 64'(fail_w[2]), 0);

        model_b(16, mp, mf, mffv, mffa);
        run(1, 50, cyc);
        chk("b_cycles", 64'(cyc), 192);
        chk("b_total", 64'(pass_w[1]) + 64'(fail_w[1]), 32);
        chk("b_pass", 64'(pass_w[1]), 64'(mp));
        chk("b_fail", 64'(fail_w[1]), 64'(mf));
        chk("b_ffv", 64'(ffv_w[1]), 64'(mffv));
        if (mffv) chk("b_ffa", 64'(ffa_w[1]), 64'(mffa));

        @(negedge clk);
        start_r[1] = 1'b1;
        @(posedge clk); #1;
        start_r[1] = 1'b0;
        n = 0;
        while (b_exp_addr != 6'h14 && n < 500) begin @(posedge clk); #1; n++; end
        chk("abort_reach_vec5", 64'(n < 500), 1);
        abort_r[1] = 1'b1;
        @(posedge clk); #1;
        abort_r[1] = 1'b0;
        chk("abort_busy", 64'(busy_w[1]), 0);
        model_b(5, mp, mf, mffv, mffa);
        chk("abort_pass", 64'(pass_w[1]), 64'(mp));
        chk("abort_fail", 64'(fail_w[1]), 64'(mf));
        chk("abort_ffv", 64'(ffv_w[1]), 64'(mffv));
        seen = 1'b0;
        repeat (20) begin @(posedge clk); #1; seen |= done_w[1]; end
        chk("abort_no_done", 64'(seen), 0);
        chk("abort_pass_hold", 64'(pass_w[1]), 64'(mp));
        chk("abort_fail_hold", 64'(fail_w[1]), 64'(mf));

        model_b(16, mp, mf, mffv, mffa);
        run(1, -1, cyc);
        chk("restart_cycles", 64'(cyc), 192);
        chk("restart_pass", 64'(pass_w[1]), 64'(mp));
        chk("restart_fail", 64'(fail_w[1]), 64'(mf));

        @(negedge clk);
        start_r[1] = 1'b1;
        @(posedge clk); #1;
        start_r[1] = 1'b0;
        n = 0;
        while (b_exp_addr != 6'h08 && n < 500) begin @(posedge clk); #1; n++; end
        chk("rst_reach_drive", 64'(n < 500), 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_busy", 64'(busy_w[1]), 0);
        chk("midrst_pass", 64'(pass_w[1]), 0);
        chk("midrst_fail", 64'(fail_w[1]), 0);
        chk("midrst_ffv", 64'(ffv_w[1]), 0);
        chk("midrst_rom_addr", 64'(b_rom_addr), 0);
        chk("midrst_exp_addr", 64'(b_exp_addr), 0);
        chk("midrst_drive", 64'({b_add_sub, b_32a, b_32b}), 0);
        chk("midrst_a_pass", 64'(pass_w[0]), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
